// File: rtl/ucode_seq_pkg.sv
// Shared state type and microcode-address helpers for ucode_sequencer.
// Build option UCODE_SEQ_PHASE_TRAP_EN adds the phase-overflow TRAP state.
package ucode_seq_pkg;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXEC  = 3'd1,
      ST_IRQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HALT  = 3'd4
`ifdef UCODE_SEQ_PHASE_TRAP_EN
      , ST_TRAP = 3'd5
`endif
   } seq_state_e;

   function automatic logic [31:0] kind_fetch(input int kw);
      return (32'd1 << kw) - 32'd1;
   endfunction

   function automatic logic [31:0] kind_int(input int kw);
      return kind_fetch(kw) - 32'd1;
   endfunction

   function automatic logic [31:0] type_fetch(input int tw);
      return (32'd1 << tw) - 32'd1;
   endfunction

   // Packs {phase, kind, type}; fields are masked to their widths.
   function automatic logic [31:0] pack_addr(
      input int          kw,
      input int          tw,
      input logic [31:0] ph,
      input logic [31:0] kind,
      input logic [31:0] typ
   );
      return (ph << (kw + tw))
           | ((kind & kind_fetch(kw)) << tw)
           | (typ & type_fetch(tw));
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins interrupt priority encoder.
module irq_prio_enc #(
   parameter int NUM_IRQ = 4,
   parameter int VEC_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic               valid_o,
   output logic [VEC_W-1:0]   idx_o,
   output logic [NUM_IRQ-1:0] onehot_o
);

   // Scan downwards so the last hit, the lowest index, wins.
   always_comb begin
      valid_o  = 1'b0;
      idx_o    = '0;
      onehot_o = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            valid_o  = 1'b1;
            idx_o    = VEC_W'(i);
            onehot_o = NUM_IRQ'(1) << i;
         end
      end
   end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: IR, phase counter, IE flag, IRQ entry, wait/halt.
// Define UCODE_SEQ_PHASE_TRAP_EN to trap on phase overflow instead of wrapping.
module ucode_sequencer
   import ucode_seq_pkg::*;
#(
   parameter int INSTR_W  = 16,
   parameter int PHASE_W  = 3,
   parameter int OPKIND_W = 3,
   parameter int OPTYPE_W = 4,
   parameter int NUM_IRQ  = 4,
   localparam int VEC_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
   localparam int ADDR_W  = PHASE_W + OPKIND_W + OPTYPE_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INSTR_W-1:0]  instr_in,
   input  logic                instr_valid,
   output logic                instr_ready,
   output logic [INSTR_W-1:0]  ir,
   input  logic [OPKIND_W-1:0] dec_op_kind,
   input  logic [OPTYPE_W-1:0] dec_op_type,
   input  logic                dec_halt,
   input  logic                dec_wait,
   input  logic                dec_ei,
   input  logic                dec_di,
   input  logic                uc_end,
   input  logic [NUM_IRQ-1:0]  irq_req,
   output logic [NUM_IRQ-1:0]  irq_ack,
   output logic [VEC_W-1:0]    irq_vec,
   output logic [PHASE_W-1:0]  phase,
   output logic [ADDR_W-1:0]   ucode_addr,
   output logic                fetch,
   output logic                ie,
   output logic                halted,
   output logic                exc_triggered
);

   localparam logic [OPKIND_W-1:0] KIND_FETCH = OPKIND_W'(kind_fetch(OPKIND_W));
   localparam logic [OPKIND_W-1:0] KIND_INT   = OPKIND_W'(kind_int(OPKIND_W));
   localparam logic [OPTYPE_W-1:0] TYPE_FETCH = OPTYPE_W'(type_fetch(OPTYPE_W));

   seq_state_e         state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               ie_q, ie_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [NUM_IRQ-1:0] ack_q, ack_d;
   logic               take_irq;

   logic               irq_valid;
   logic [VEC_W-1:0]   irq_idx;
   logic [NUM_IRQ-1:0] irq_onehot;

   irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .VEC_W   (VEC_W)
   ) u_prio (
      .req_i    (irq_req),
      .valid_o  (irq_valid),
      .idx_o    (irq_idx),
      .onehot_o (irq_onehot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         phase_q <= '0;
         ir_q    <= '0;
         ie_q    <= 1'b0;
         vec_q   <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         ir_q    <= ir_d;
         ie_q    <= ie_d;
         vec_q   <= vec_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      ir_d     = ir_q;
      ie_d     = ie_q;
      vec_d    = vec_q;
      ack_d    = '0;
      take_irq = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            if (ie_q && irq_valid) begin
               take_irq = 1'b1;
            end else if (instr_valid) begin
               ir_d    = instr_in;
               phase_d = '0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC, ST_IRQ: begin
            if (uc_end) begin
               phase_d = '0;
               state_d = ST_FETCH;
               if (state_q == ST_EXEC) begin
                  if (dec_halt)      state_d = ST_HALT;
                  else if (dec_wait) state_d = ST_WAIT;
                  if (dec_ei)        ie_d = 1'b1;
                  else if (dec_di)   ie_d = 1'b0;
               end
            end else begin
               phase_d = phase_q + PHASE_W'(1);
`ifdef UCODE_SEQ_PHASE_TRAP_EN
               if (&phase_q) begin
                  phase_d = '0;
                  state_d = ST_TRAP;
               end
`endif
            end
         end
         ST_WAIT: begin
            phase_d = '0;
            if (irq_valid) begin
               if (ie_q) take_irq = 1'b1;
               else      state_d  = ST_FETCH;
            end
         end
`ifdef UCODE_SEQ_PHASE_TRAP_EN
         ST_TRAP: begin
            ie_d    = 1'b0;
            phase_d = '0;
            state_d = ST_FETCH;
         end
`endif
         default: ;
      endcase
      if (take_irq) begin
         state_d = ST_IRQ;
         vec_d   = irq_idx;
         ack_d   = irq_onehot;
         ie_d    = 1'b0;
         phase_d = '0;
      end
   end

   always_comb begin
      fetch         = 1'b0;
      instr_ready   = 1'b0;
      halted        = 1'b0;
      exc_triggered = 1'b0;
      ucode_addr    = ADDR_W'(pack_addr(OPKIND_W, OPTYPE_W, 32'(phase_q),
                                        32'(KIND_FETCH), 32'(TYPE_FETCH)));
      unique case (state_q)
         ST_FETCH: begin
            fetch       = 1'b1;
            instr_ready = !(ie_q && irq_valid);
         end
         ST_EXEC: begin
            ucode_addr = ADDR_W'(pack_addr(OPKIND_W, OPTYPE_W, 32'(phase_q),
                                           32'(dec_op_kind), 32'(dec_op_type)));
         end
         ST_IRQ: begin
            ucode_addr = ADDR_W'(pack_addr(OPKIND_W, OPTYPE_W, 32'(phase_q),
                                           32'(KIND_INT), 32'(vec_q)));
         end
         ST_HALT: halted = 1'b1;
`ifdef UCODE_SEQ_PHASE_TRAP_EN
         ST_TRAP: begin
            exc_triggered = 1'b1;
            ucode_addr    = ADDR_W'(pack_addr(OPKIND_W, OPTYPE_W, 32'd0,
                                              32'(KIND_INT), 32'(TYPE_FETCH)));
         end
`endif
         default: ;
      endcase
   end

   assign ir      = ir_q;
   assign ie      = ie_q;
   assign phase   = phase_q;
   assign irq_vec = vec_q;
   assign irq_ack = ack_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed scenarios then random traffic,
// checked every cycle against a rule-level reference model.
module tb_ucode_sequencer;

   localparam int M_FETCH = 0;
   localparam int M_EXEC  = 1;
   localparam int M_IRQ   = 2;
   localparam int M_WAIT  = 3;
   localparam int M_HALT  = 4;
   localparam int M_TRAP  = 5;
`ifdef UCODE_SEQ_PHASE_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] ir;
   logic [2:0]  dec_op_kind;
   logic [3:0]  dec_op_type;
   logic        dec_halt, dec_wait, dec_ei, dec_di;
   logic        uc_end;
   logic [3:0]  irq_req;
   logic [3:0]  irq_ack;
   logic [1:0]  irq_vec;
   logic [2:0]  phase;
   logic [9:0]  ucode_addr;
   logic        fetch, ie, halted, exc_triggered;

   ucode_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_in      (instr_in),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .ir            (ir),
      .dec_op_kind   (dec_op_kind),
      .dec_op_type   (dec_op_type),
      .dec_halt      (dec_halt),
      .dec_wait      (dec_wait),
      .dec_ei        (dec_ei),
      .dec_di        (dec_di),
      .uc_end        (uc_end),
      .irq_req       (irq_req),
      .irq_ack       (irq_ack),
      .irq_vec       (irq_vec),
      .phase         (phase),
      .ucode_addr    (ucode_addr),
      .fetch         (fetch),
      .ie            (ie),
      .halted        (halted),
      .exc_triggered (exc_triggered)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int          m_mode;
   int          m_ph;
   int          m_vec;
   logic [15:0] m_ir;
   bit          m_ie;
   logic [3:0]  m_ack;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_FETCH;
      m_ph   = 0;
      m_vec  = 0;
      m_ir   = 16'h0;
      m_ie   = 1'b0;
      m_ack  = 4'h0;
   endtask

   task automatic enter_irq(input logic [3:0] req);
      for (int i = 0; i < 4; i++) begin
         if (req[i]) begin
            m_vec = i;
            break;
         end
      end
      m_ack  = 4'(1 << m_vec);
      m_ie   = 1'b0;
      m_ph   = 0;
      m_mode = M_IRQ;
   endtask

   task automatic model_update();
      logic [3:0] req;
      req   = irq_req;
      m_ack = 4'h0;
      case (m_mode)
         M_FETCH: begin
            if (m_ie && req != 0) enter_irq(req);
            else if (instr_valid) begin
               m_ir   = instr_in;
               m_ph   = 0;
               m_mode = M_EXEC;
            end
         end
         M_EXEC, M_IRQ: begin
            if (uc_end) begin
               if (m_mode == M_EXEC) begin
                  if (dec_ei) m_ie = 1'b1;
                  if (dec_di) m_ie = 1'b0;
                  m_mode = dec_halt ? M_HALT : (dec_wait ? M_WAIT : M_FETCH);
               end else begin
                  m_mode = M_FETCH;
               end
               m_ph = 0;
            end else if (TRAP_EN && m_ph == 7) begin
               m_mode = M_TRAP;
               m_ph   = 0;
            end else begin
               m_ph = (m_ph + 1) % 8;
            end
         end
         M_WAIT: begin
            if (req != 0) begin
               if (m_ie) enter_irq(req);
               else      m_mode = M_FETCH;
            end
         end
         M_TRAP: begin
            m_ie   = 1'b0;
            m_ph   = 0;
            m_mode = M_FETCH;
         end
         default: ;
      endcase
   endtask

   task automatic check_outputs();
      int ea;
      bool_chk: begin
         chk("fetch", 32'(fetch), 32'(m_mode == M_FETCH));
         chk("instr_ready", 32'(instr_ready),
             32'(m_mode == M_FETCH && !(m_ie && irq_req != 0)));
         chk("halted", 32'(halted), 32'(m_mode == M_HALT));
         chk("exc_triggered", 32'(exc_triggered), 32'(m_mode == M_TRAP));
      end
      chk("phase", 32'(phase), 32'(m_ph));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("ie", 32'(ie), 32'(m_ie));
      chk("irq_vec", 32'(irq_vec), 32'(m_vec));
      chk("irq_ack", 32'(irq_ack), 32'(m_ack));
      ea = -1;
      case (m_mode)
         M_FETCH: ea = m_ph * 128 + 7 * 16 + 15;
         M_EXEC:  ea = m_ph * 128 + int'(dec_op_kind) * 16 + int'(dec_op_type);
         M_IRQ:   ea = m_ph * 128 + 6 * 16 + m_vec;
         M_TRAP:  ea = 6 * 16 + 15;
         default: ;
      endcase
      if (ea >= 0) chk("ucode_addr", 32'(ucode_addr), 32'(ea));
   endtask

   task automatic step();
      #1 check_outputs();
      @(posedge clk);
      if (rst_n) model_update();
      else       model_reset();
      @(negedge clk);
   endtask

   task automatic clear_dec();
      uc_end   = 1'b0;
      dec_halt = 1'b0;
      dec_wait = 1'b0;
      dec_ei   = 1'b0;
      dec_di   = 1'b0;
   endtask

   // Accepts one instruction and ends it immediately with the given strobes.
   task automatic run_instr(input logic ei, input logic wt, input logic hl);
      instr_valid = 1'b1;
      instr_in    = 16'($urandom);
      step();
      instr_valid = 1'b0;
      uc_end      = 1'b1;
      dec_ei      = ei;
      dec_wait    = wt;
      dec_halt    = hl;
      step();
      clear_dec();
   endtask

   int exc_seen;

   initial begin
      rst_n       = 1'b0;
      instr_in    = 16'h0;
      instr_valid = 1'b0;
      dec_op_kind = 3'd3;
      dec_op_type = 4'd5;
      irq_req     = 4'h0;
      clear_dec();
      model_reset();
      @(negedge clk);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Basic instruction: three phases then back to fetch.
      instr_valid = 1'b1;
      instr_in    = 16'h2A5B;
      step();
      instr_valid = 1'b0;
      step();
      step();
      uc_end = 1'b1;
      step();
      clear_dec();
      chk("ir_loaded", 32'(ir), 32'h2A5B);
      chk("fetch_after_end", 32'(fetch), 32'd1);
      chk("phase_after_end", 32'(phase), 32'd0);

      // Pending irq ignored with ie=0, taken after EI.
      irq_req = 4'b0100;
      step();
      step();
      chk("no_ack_ie0", 32'(irq_ack), 32'h0);
      run_instr(1'b1, 1'b0, 1'b0);
      step();
      chk("ack_line2", 32'(irq_ack), 32'h4);
      chk("vec_line2", 32'(irq_vec), 32'd2);
      chk("ie_cleared", 32'(ie), 32'd0);
      step();
      chk("ack_one_cycle", 32'(irq_ack), 32'h0);
      irq_req = 4'h0;
      uc_end  = 1'b1;
      step();
      clear_dec();

      // Two pending lines: lowest wins.
      run_instr(1'b1, 1'b0, 1'b0);
      irq_req = 4'b1010;
      step();
      chk("vec_line1", 32'(irq_vec), 32'd1);
      chk("ack_line1", 32'(irq_ack), 32'h2);
      chk("addr_type_vec", 32'(ucode_addr[3:0]), 32'd1);
      irq_req = 4'h0;
      uc_end  = 1'b1;
      step();
      clear_dec();

      // WAIT, then woken by irq with ie=0.
      run_instr(1'b0, 1'b1, 1'b0);
      step();
      chk("wait_not_ready", 32'(instr_ready), 32'd0);
      irq_req = 4'b0001;
      step();
      chk("wait_to_fetch", 32'(fetch), 32'd1);
      chk("wait_no_ack", 32'(irq_ack), 32'h0);
      irq_req = 4'h0;
      step();

      // Halt wins over pending irq; only reset leaves.
      run_instr(1'b1, 1'b0, 1'b0);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      uc_end   = 1'b1;
      dec_halt = 1'b1;
      irq_req  = 4'b0001;
      step();
      clear_dec();
      step();
      step();
      chk("halted_stays", 32'(halted), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_fetch", 32'(fetch), 32'd1);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_ie", 32'(ie), 32'd0);
      chk("rst_ir", 32'(ir), 32'd0);
      chk("rst_phase", 32'(phase), 32'd0);
      model_reset();
      irq_req = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Long microprogram: wrap or trap at the last phase.
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      exc_seen = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         if (exc_triggered) exc_seen++;
      end
      chk("exc_count", 32'(exc_seen), TRAP_EN ? 32'd1 : 32'd0);
      uc_end = 1'b1;
      step();
      clear_dec();

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         instr_valid = 1'($urandom_range(0, 1));
         instr_in    = 16'($urandom);
         dec_op_kind = 3'($urandom);
         dec_op_type = 4'($urandom);
         uc_end      = ($urandom_range(0, 3) == 0);
         dec_ei      = ($urandom_range(0, 3) == 0);
         dec_di      = !dec_ei && ($urandom_range(0, 5) == 0);
         dec_wait    = ($urandom_range(0, 7) == 0);
         dec_halt    = ($urandom_range(0, 50) == 0);
         irq_req     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         if (m_mode == M_HALT && $urandom_range(0, 2) == 0) begin
            model_reset();
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
Parametrised microcode sequencer that owns the instruction register, the microcode phase counter and the interrupt-enable flag. It forms the microcode ROM address from a registered phase and the op_kind/op_type fields supplied by the combinational decoder. It also sequences fetch, execute, interrupt entry, wait and halt. It sits between the fetch unit (valid/ready), the decoder (feeds ir, receives decode fields) and the microcode ROM.

Parameters:
INSTR_W, 16, instruction register width
PHASE_W, 3, phase counter width (max 2^PHASE_W phases per instruction)
OPKIND_W, 3, op_kind field width
OPTYPE_W, 4, op_type field width
NUM_IRQ, 4, interrupt request lines; must be <= 2^OPTYPE_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
instr_in  in  INSTR_W  fetched instruction
instr_valid  in  1  instr_in valid
instr_ready  out  1  sequencer accepts instruction
ir  out  INSTR_W  instruction register, drives decoder
dec_op_kind  in  OPKIND_W  decoder op_kind
dec_op_type  in  OPTYPE_W  decoder op_type
dec_halt, dec_wait, dec_ei, dec_di  in  1 each  decoder misc-instruction strobes
uc_end  in  1  end-of-instruction bit of the current microcommand
irq_req  in  NUM_IRQ  level interrupt requests
irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge
irq_vec  out  max(1,$clog2(NUM_IRQ))  index of interrupt being serviced
phase  out  PHASE_W  current phase
ucode_addr  out  PHASE_W+OPKIND_W+OPTYPE_W  {phase, kind, type}
fetch  out  1  sequencer in FETCH
ie  out  1  interrupt enable
halted  out  1  sequencer in HALT
exc_triggered  out  1  phase-overflow trap (see Optional Feature)

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n.
- Reset values: state FETCH, phase 0, ir 0, ie 0, irq_vec 0, irq_ack 0, halted 0, exc_triggered 0. In the reset state fetch=1 and instr_ready=1.
- States: FETCH, EXEC, IRQ, WAIT, HALT, plus TRAP when the optional feature is compiled in.
- FETCH:
  - Outputs: fetch=1. ucode_addr={phase, KIND_FETCH=all-ones, TYPE_FETCH=all-ones}.
  - If ie && |irq_req: instr_ready=0, go to IRQ. The lowest-index pending line wins; latch irq_vec, pulse irq_ack[vec] for one cycle, clear ie, phase<=0.
  - Otherwise instr_ready=1. On instr_valid&&instr_ready: ir<=instr_in, phase<=0, go to EXEC.
- EXEC:
  - ucode_addr={phase, dec_op_kind, dec_op_type}. This path is combinational from ir through the decoder. ucode_addr and phase are otherwise registered.
  - If !uc_end: phase<=phase+1.
  - If uc_end, the next state is chosen by priority: dec_halt -> HALT; dec_wait -> WAIT; else FETCH. Phase is cleared to 0 in all three cases.
  - On that same uc_end edge: dec_ei sets ie, dec_di clears ie. The new ie is seen by FETCH from the next cycle on.
- IRQ:
  - ucode_addr={phase, KIND_INT=all-ones minus 1, zero-extended irq_vec}.
  - Phase advances until uc_end, then go to FETCH with phase<=0.
  - New requests are ignored while in IRQ.
- WAIT: hold phase 0. On any |irq_req: if ie go to IRQ (same entry actions as from FETCH); if !ie go to FETCH.
- HALT: halted=1 and instr_ready=0. Only rst_n leaves HALT.
- Phase wrap without the feature: phase wraps modulo 2^PHASE_W, silently.
- Reset mid-instruction: everything returns to the reset values asynchronously, with no partial commit.
- Simultaneous events:
  - uc_end together with halt and a pending irq: HALT wins.
  - instr_valid and a pending enabled irq in FETCH: irq wins and the instruction is not consumed (instr_ready=0).
- irq_ack is registered and pulses in the first IRQ cycle.

Optional Feature:
UCODE_SEQ_PHASE_TRAP_EN.
- Defined: in EXEC or IRQ, if phase==2^PHASE_W-1 && !uc_end, go to TRAP instead of wrapping. TRAP lasts one cycle with exc_triggered=1, ucode_addr={0, KIND_INT, all-ones type}, ie<=0, then FETCH with phase 0.
- Undefined: no TRAP state, exc_triggered is tied to 0, and phase wraps.

Decomposition:
- Package ucode_seq_pkg holds:
  - the state enum typedef;
  - KIND_FETCH, KIND_INT and TYPE_FETCH as functions of the widths;
  - the address-pack function {phase, kind, type}.
- One sub-module, irq_prio_enc (parametrised by NUM_IRQ): lowest-index priority encoder producing a valid flag, the index and the one-hot acknowledge.

Test Plan:
- Reset, then instr_valid with instr_in=16'h2A5B, and uc_end asserted at phase 2 -> ir=16'h2A5B. ucode_addr steps through {0..2, kind, type}, then fetch=1 and phase=0.
- ie=0 and irq_req=4'b0100 in FETCH -> no IRQ entry. Execute an instruction with dec_ei at uc_end -> ie=1, IRQ entered next FETCH, irq_ack=4'b0100 for exactly one cycle, irq_vec=2, ie=0.
- irq_req=4'b1010 with ie=1 -> irq_vec=1, irq_ack=4'b0010, and ucode_addr type field=1.
- dec_wait at uc_end -> WAIT with instr_ready=0. Then irq_req=4'b0001 with ie=0 -> FETCH, no ack.
- dec_halt and a pending irq at the same uc_end -> halted=1 permanently. Assert rst_n=0 mid-cycle -> all outputs return to reset values immediately.
- Hold uc_end=0 for 8 cycles: with UCODE_SEQ_PHASE_TRAP_EN, phase 7 is followed by exc_triggered=1 for one cycle, then FETCH. Without it, phase wraps 7->0 and exc_triggered stays 0.
